controle_magnetron_potencia: RTL and testbench
==============================================

# controle_magnetron_potencia

Parametrised magnetron controller with selectable power level. It replaces the purely combinational latch-based control with a clocked three-state controller (idle / cooking / paused) and a duty-cycle window generator, so the magnetron is pulsed on for `level` cycles out of every `PERIOD` cycles. It sits between the front-panel/door/timer logic and the magnetron driver, and adds a zero-latency door interlock on `mag_on`.

## Interface
- `PERIOD`, default 10: cycles per duty window, minimum 2.
- `LEVEL_W`, default 4: width of `power_level`, and must satisfy 2^LEVEL_W > PERIOD.
- `clk` input, 1 bit: single system clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `startn` input, 1 bit: start request, active-low, level-sensitive.
- `stopn` input, 1 bit: stop/pause request, active-low.
- `clearn` input, 1 bit: clear/cancel request, active-low.
- `door_closed` input, 1 bit: 1 = door closed.
- `timer_done` input, 1 bit: 1 = cooking timer expired.
- `power_level` input, LEVEL_W bits: on-cycles per window. 0 or ≥PERIOD means full power.
- `mag_on` output, 1 bit: magnetron drive.
- `cooking` output, 1 bit: state == COOK.
- `paused` output, 1 bit: state == PAUSE.

## Operation
- States: IDLE, COOK, PAUSE. Reset → IDLE, phase = 0, level_q = PERIOD.
- Priority is evaluated each cycle, and the first matching rule wins:
  - `clearn`=0 → IDLE, from any state.
  - In COOK: `stopn`=0 or `door_closed`=0 → PAUSE.
  - In COOK or PAUSE: `timer_done`=1 → IDLE.
  - In IDLE or PAUSE: `startn`=0 and `stopn`=1 and `door_closed`=1 and `timer_done`=0 → COOK.
  - Otherwise the state holds.
- Start and stop asserted together: stop wins, and the state does not enter COOK.
- Holding `startn` low in COOK has no effect.
- Phase counter: 0..PERIOD-1, advances only in COOK and wraps PERIOD-1 → 0.
  - Forced to 0 on every entry to COOK.
  - Held at 0 outside COOK.
- level_q: the effective level, equal to PERIOD if `power_level`==0 or `power_level`≥PERIOD, else `power_level`.
  - Captured on entry to COOK and at each wrap to phase 0.
  - A mid-window change of `power_level` takes effect at the next window.
- `mag_on` = (state==COOK) & (phase < level_q) & `door_closed`.
  - It is combinational from registered state plus the live `door_closed`, so door opening kills `mag_on` in the same cycle.
  - No other input reaches `mag_on` combinationally.
- `cooking` and `paused` are decoded from the state register only.

## Timing
- Reset values: `mag_on`=0, `cooking`=0, `paused`=0.
- Input sampled at edge N → state visible after edge N (1-cycle latency). `mag_on` rises in the first COOK cycle, phase 0.
- Windows are exactly PERIOD cycles long. `mag_on` is high for phases 0..level_q-1.
- Full power: `mag_on` stays high continuously in COOK, with no gap at wrap.
- Resume from PAUSE restarts the window at phase 0.
- Door opening in COOK:
  - `mag_on` drops in the same cycle, combinationally.
  - The state goes to PAUSE at the next edge.
  - Door closing alone does not resume cooking; a new `startn` is required.
- `rst` mid-COOK → IDLE next edge; `mag_on` is 0 from that edge.
- `clearn` and `timer_done` in the same cycle → IDLE.
- `timer_done` held high blocks start.

## Structure
- Package `magnetron_pkg` holds:
  - the state typedef (IDLE=2'b00, COOK=2'b01, PAUSE=2'b10);
  - default constants `PERIOD_DEF`=10 and `LEVEL_W_DEF`=4.
- Sub-module `gerador_ciclo_trabalho` (parametrised by PERIOD and LEVEL_W) contains the phase counter, level_q capture and the on-window compare. Its signals:
  - inputs: `run`, `restart`, `power_level`;
  - output: `window_on`.
- The top module holds the FSM and the final `mag_on` AND with `door_closed`.

## Test plan
- Reset, then door closed and `startn` low for 1 cycle with `power_level`=3 → `cooking`=1 next cycle. `mag_on` pattern is 1,1,1,0,0,0,0,0,0,0 repeating for 3 windows.
- `power_level`=0, then 15 → `mag_on` stays constantly 1 in COOK for 30 cycles.
- COOK at level 5: open door at phase 2 → `mag_on`=0 the same cycle and `paused`=1 next. Close door → still PAUSE. `startn` → COOK, with phase restarting at 0.
- COOK: `stopn`=0 together with `startn`=0 → PAUSE. Then `clearn`=0 → IDLE with all outputs 0.
- COOK at level 7: change to 2 at phase 4 → the current window gives 7 on-cycles, the next gives 2.
- `timer_done`=1 in COOK → IDLE next cycle. `rst` pulse mid-COOK → all outputs 0 after that edge.

Source files
------------

// File: rtl/magnetron_pkg.sv
// Shared types and default sizing for the magnetron power controller.
package magnetron_pkg;

   localparam int PERIOD_DEF  = 10;
   localparam int LEVEL_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COOK  = 2'b01,
      PAUSE = 2'b10
   } state_t;

endpackage

// File: rtl/gerador_ciclo_trabalho.sv
// Duty-window generator: phase counter over PERIOD cycles, power level latched per
// window, window_on high for the first level_q phases of each window.
module gerador_ciclo_trabalho #(
   parameter int PERIOD  = 10,
   parameter int LEVEL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               restart,
   input  logic [LEVEL_W-1:0] power_level,
   output logic               window_on
);

   // The phase fits in LEVEL_W bits because 2^LEVEL_W > PERIOD.
   localparam logic [LEVEL_W-1:0] PERIOD_L = LEVEL_W'(PERIOD);
   localparam logic [LEVEL_W-1:0] LAST_PH  = LEVEL_W'(PERIOD - 1);

   logic [LEVEL_W-1:0] phase;
   logic [LEVEL_W-1:0] level_q;
   logic [LEVEL_W-1:0] level_eff;

   always_comb begin
      level_eff = power_level;
      if (power_level == '0 || power_level >= PERIOD_L) begin
         level_eff = PERIOD_L;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= '0;
         level_q <= PERIOD_L;
      end else if (restart) begin
         phase   <= '0;
         level_q <= level_eff;
      end else if (run) begin
         if (phase == LAST_PH) begin
            phase   <= '0;
            level_q <= level_eff;
         end else begin
            phase <= phase + LEVEL_W'(1);
         end
      end else begin
         phase <= '0;
      end
   end

   assign window_on = (phase < level_q);

endmodule

// File: rtl/controle_magnetron_potencia.sv
// Magnetron controller: idle/cook/pause sequencing with a duty-cycled drive and a
// zero-latency door interlock on mag_on.
//
//   state | meaning
//   IDLE  | magnetron off, waiting for a valid start
//   COOK  | magnetron pulsed by the duty window
//   PAUSE | stopped or door opened; needs a fresh start to resume
module controle_magnetron_potencia
   import magnetron_pkg::*;
#(
   parameter int PERIOD  = PERIOD_DEF,
   parameter int LEVEL_W = LEVEL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               startn,
   input  logic               stopn,
   input  logic               clearn,
   input  logic               door_closed,
   input  logic               timer_done,
   input  logic [LEVEL_W-1:0] power_level,
   output logic               mag_on,
   output logic               cooking,
   output logic               paused
);

   state_t state;
   state_t state_nx;
   logic   start_ok;
   logic   run;
   logic   restart;
   logic   window_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign start_ok = !startn && stopn && door_closed && !timer_done;

   always_comb begin
      state_nx = state;
      if (!clearn) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) state_nx = COOK;
            end
            COOK: begin
               if (!stopn || !door_closed) state_nx = PAUSE;
               else if (timer_done)        state_nx = IDLE;
            end
            PAUSE: begin
               if (timer_done)    state_nx = IDLE;
               else if (start_ok) state_nx = COOK;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Every entry into COOK restarts the window at phase 0.
   assign restart = (state_nx == COOK) && (state != COOK);
   assign run     = (state_nx == COOK) && (state == COOK);

   gerador_ciclo_trabalho #(
      .PERIOD  (PERIOD),
      .LEVEL_W (LEVEL_W)
   ) u_gerador (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .restart     (restart),
      .power_level (power_level),
      .window_on   (window_on)
   );

   assign mag_on  = (state == COOK) && window_on && door_closed;
   assign cooking = (state == COOK);
   assign paused  = (state == PAUSE);

endmodule

// File: tb/tb_controle_magnetron_potencia.sv
// Self-checking bench for controle_magnetron_potencia: vector table plus
// hand-built sequences for duty windows, door interlock and level changes.
module tb_controle_magnetron_potencia;

   logic       clk;
   logic       rst;
   logic       startn;
   logic       stopn;
   logic       clearn;
   logic       door_closed;
   logic       timer_done;
   logic [3:0] power_level;
   logic       mag_on;
   logic       cooking;
   logic       paused;

   typedef struct packed {
      logic mag;
      logic cook;
      logic paus;
   } exp_t;

   typedef struct {
      logic       r;
      logic       s;
      logic       st;
      logic       c;
      logic       d;
      logic       t;
      logic [3:0] l;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   tests;
   int   failed;

   controle_magnetron_potencia #(.PERIOD(10), .LEVEL_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .startn      (startn),
      .stopn       (stopn),
      .clearn      (clearn),
      .door_closed (door_closed),
      .timer_done  (timer_done),
      .power_level (power_level),
      .mag_on      (mag_on),
      .cooking     (cooking),
      .paused      (paused)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, s, st, c, d, t, input logic [3:0] l,
                               input logic em, ec, ep);
      vec_t v;
      v.r = r; v.s = s; v.st = st; v.c = c; v.d = d; v.t = t; v.l = l;
      v.e = '{mag: em, cook: ec, paus: ep};
      return v;
   endfunction

   task automatic check(input string nm);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $display("FAIL %s: scoreboard empty", nm);
         return;
      end
      e = sb.pop_front();
      if (mag_on !== e.mag || cooking !== e.cook || paused !== e.paus) begin
         failed++;
         $display("FAIL %s: got mag_on=%b cooking=%b paused=%b, expected mag_on=%b cooking=%b paused=%b",
                  nm, mag_on, cooking, paused, e.mag, e.cook, e.paus);
      end
   endtask

   // Drive at the falling edge, compare just after the next rising edge.
   task automatic cyc(input vec_t v, input string nm);
      @(negedge clk);
      rst = v.r; startn = v.s; stopn = v.st; clearn = v.c;
      door_closed = v.d; timer_done = v.t; power_level = v.l;
      sb.push_back(v.e);
      @(posedge clk);
      #1;
      check(nm);
   endtask

   task automatic go_idle();
      cyc(mk(0,1,1,0,1,0,4'd5, 0,0,0), "clear_to_idle");
   endtask

   initial begin
      tests = 0;
      failed = 0;
      rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
      door_closed = 1'b1; timer_done = 1'b0; power_level = 4'd5;

      //           r s st c d t lvl    mag cook paus
      tbl.push_back(mk(1,1,1,1,1,0,4'd5, 0,0,0));  // reset
      tbl.push_back(mk(0,1,1,1,1,0,4'd5, 0,0,0));  // idle
      tbl.push_back(mk(0,0,0,1,1,0,4'd5, 0,0,0));  // start+stop in idle
      tbl.push_back(mk(0,0,1,1,1,1,4'd5, 0,0,0));  // timer blocks start
      tbl.push_back(mk(0,0,1,1,0,0,4'd5, 0,0,0));  // open door blocks start
      tbl.push_back(mk(0,0,1,1,1,0,4'd5, 1,1,0));  // start -> cook phase 0
      tbl.push_back(mk(0,0,1,1,1,0,4'd5, 1,1,0));  // startn held, phase 1
      tbl.push_back(mk(0,0,0,1,1,0,4'd5, 0,0,1));  // stop+start in cook -> pause
      tbl.push_back(mk(0,1,1,1,1,0,4'd5, 0,0,1));  // pause holds
      tbl.push_back(mk(0,1,1,0,1,0,4'd5, 0,0,0));  // clear -> idle
      tbl.push_back(mk(0,0,1,1,1,0,4'd5, 1,1,0));  // cook
      tbl.push_back(mk(0,1,1,0,1,1,4'd5, 0,0,0));  // clear+timer -> idle
      tbl.push_back(mk(0,0,1,1,1,0,4'd5, 1,1,0));  // cook
      tbl.push_back(mk(0,1,1,1,1,1,4'd5, 0,0,0));  // timer in cook -> idle
      tbl.push_back(mk(0,0,1,1,1,0,4'd5, 1,1,0));  // cook
      tbl.push_back(mk(1,1,1,1,1,0,4'd5, 0,0,0));  // reset mid-cook
      tbl.push_back(mk(1,0,1,1,1,0,4'd5, 0,0,0));  // reset beats start
      tbl.push_back(mk(0,0,1,1,1,0,4'd0, 1,1,0));  // cook full power
      tbl.push_back(mk(0,1,0,1,1,0,4'd0, 0,0,1));  // stop -> pause
      tbl.push_back(mk(0,0,1,1,1,1,4'd0, 0,0,0));  // timer in pause beats start
      tbl.push_back(mk(0,0,1,1,1,0,4'd5, 1,1,0));  // cook
      tbl.push_back(mk(0,1,1,0,1,0,4'd5, 0,0,0));  // clear -> idle

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i], $sformatf("vec%0d", i));
      end

      // Level 3: on for phases 0..2 of each 10-cycle window, three windows.
      for (int i = 0; i < 30; i++) begin
         cyc(mk(0, (i == 0) ? 1'b0 : 1'b1, 1,1,1,0, 4'd3, ((i % 10) < 3), 1, 0),
             $sformatf("lvl3_c%0d", i));
      end
      go_idle();

      // Full power via 0 then 15: no gap across window wraps.
      for (int i = 0; i < 30; i++) begin
         cyc(mk(0, (i == 0) ? 1'b0 : 1'b1, 1,1,1,0, (i < 15) ? 4'd0 : 4'd15, 1, 1, 0),
             $sformatf("full_c%0d", i));
      end
      go_idle();

      // Level 5, door opens during phase 2.
      cyc(mk(0,0,1,1,1,0,4'd5, 1,1,0), "door_ph0");
      cyc(mk(0,1,1,1,1,0,4'd5, 1,1,0), "door_ph1");
      cyc(mk(0,1,1,1,1,0,4'd5, 1,1,0), "door_ph2");
      @(negedge clk);
      door_closed = 1'b0;
      sb.push_back('{mag: 1'b0, cook: 1'b1, paus: 1'b0});
      #1;
      check("door_kill_same_cycle");
      sb.push_back('{mag: 1'b0, cook: 1'b0, paus: 1'b1});
      @(posedge clk);
      #1;
      check("door_to_pause");
      cyc(mk(0,1,1,1,1,0,4'd5, 0,0,1), "door_closed_still_pause");
      cyc(mk(0,1,1,1,1,0,4'd5, 0,0,1), "door_closed_still_pause2");
      for (int i = 0; i < 10; i++) begin
         cyc(mk(0, (i == 0) ? 1'b0 : 1'b1, 1,1,1,0, 4'd5, (i < 5), 1, 0),
             $sformatf("resume_c%0d", i));
      end
      go_idle();

      // Level 7 changed to 2 at phase 4: this window 7 on, next window 2 on.
      for (int i = 0; i < 20; i++) begin
         cyc(mk(0, (i == 0) ? 1'b0 : 1'b1, 1,1,1,0, (i < 4) ? 4'd7 : 4'd2,
                (i < 10) ? (i < 7) : ((i - 10) < 2), 1, 0),
             $sformatf("lvlchg_c%0d", i));
      end
      go_idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
      $fatal(1, "watchdog");
   end

endmodule
